// File: rtl/half_adder_nor.sv
// WIDTH-lane registered half adder whose datapath uses only 2-input NOR cells.
// Optional shadow self-check enabled by defining HALF_ADDER_SELFCHECK_EN.

module half_adder_nor_nor2 (
  input  logic x,
  input  logic y,
  output logic z
);
  assign z = ~(x | y);
endmodule

module half_adder_nor #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_count,
  output logic             err
);

  logic [WIDTH-1:0] s_net;
  logic [WIDTH-1:0] c_net;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic n1, n2, n3, xn, na, nb;
    half_adder_nor_nor2 u_n1 (.x(a[i]), .y(b[i]), .z(n1));
    half_adder_nor_nor2 u_n2 (.x(a[i]), .y(n1),   .z(n2));
    half_adder_nor_nor2 u_n3 (.x(b[i]), .y(n1),   .z(n3));
    half_adder_nor_nor2 u_xn (.x(n2),   .y(n3),   .z(xn));
    half_adder_nor_nor2 u_s  (.x(xn),   .y(xn),   .z(s_net[i]));
    half_adder_nor_nor2 u_na (.x(a[i]), .y(a[i]), .z(na));
    half_adder_nor_nor2 u_nb (.x(b[i]), .y(b[i]), .z(nb));
    half_adder_nor_nor2 u_c  (.x(na),   .y(nb),   .z(c_net[i]));
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    op_count_d  = op_count_q;
    if (rst) begin
      sum_d      = '0;
      carry_d    = '0;
      op_count_d = '0;
    end else if (in_valid) begin
      sum_d       = s_net;
      carry_d     = c_net;
      out_valid_d = 1'b1;
      // Saturate rather than wrap.
      if (op_count_q != {CNT_W{1'b1}}) op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    sum_q       <= sum_d;
    carry_q     <= carry_d;
    out_valid_q <= out_valid_d;
    op_count_q  <= op_count_d;
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;
  assign op_count  = op_count_q;

`ifdef HALF_ADDER_SELFCHECK_EN
  logic [WIDTH-1:0] lane_bad;
  logic             err_q, err_d;

  // Behavioural shadow; only feeds the error flag, never the datapath.
  assign lane_bad = ((a ^ b) ^ s_net) | ((a & b) ^ c_net);

  always_comb begin
    err_d = err_q;
    if (rst) begin
      err_d = 1'b0;
    end else if (in_valid && (lane_bad != '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    err_q <= err_d;
  end

  assign err = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (lane_bad[i]) $warning("selfcheck t=%0t lane=%0d a=%b b=%b", $time, i, a[i], b[i]);
      end
    end
  end
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_half_adder_nor.sv
// Bench for half_adder_nor: directed vector table plus randomized run against a lane-arithmetic model.

module tb_half_adder_nor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b;

  logic [3:0]  sum, carry;
  logic        out_valid, err;
  logic [15:0] op_count;

  logic        s_sum, s_carry, s_out_valid, s_err;
  logic [1:0]  s_op_count;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  logic [3:0] m_sum, m_carry;
  logic       m_ov, m_err;
  int         m_cnt;

  always #5 clk = ~clk;

  half_adder_nor #(.WIDTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .sum(sum), .carry(carry), .out_valid(out_valid), .op_count(op_count), .err(err)
  );

  half_adder_nor #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0]), .b(b[0]),
    .sum(s_sum), .carry(s_carry), .out_valid(s_out_valid), .op_count(s_op_count), .err(s_err)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] e_sum;
    logic [3:0] e_carry;
    logic       e_ov;
    int         e_cnt;
    int         e_sat;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic iv, input logic [3:0] av,
                            input logic [3:0] bv);
    if (r) begin
      m_sum = '0; m_carry = '0; m_ov = 1'b0; m_cnt = 0; m_err = 1'b0;
    end else if (iv) begin
      for (int i = 0; i < 4; i++) begin
        int t;
        t = int'(av[i]) + int'(bv[i]);
        m_sum[i]   = (t % 2) != 0;
        m_carry[i] = (t / 2) != 0;
      end
      m_ov = 1'b1;
      m_cnt++;
    end else begin
      m_ov = 1'b0;
    end
  endtask

  task automatic apply(input logic r, input logic iv, input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    rst = r; in_valid = iv; a = av; b = bv;
    @(posedge clk);
    #1;
    model_step(r, iv, av, bv);
  endtask

  task automatic check_model(input string tag);
    int sat_w, sat_n;
    sat_w = (m_cnt > 65535) ? 65535 : m_cnt;
    sat_n = (m_cnt > 3) ? 3 : m_cnt;
    check({tag, ".sum"}, 64'(sum), 64'(m_sum));
    check({tag, ".carry"}, 64'(carry), 64'(m_carry));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    check({tag, ".op_count"}, 64'(op_count), 64'(sat_w));
    check({tag, ".err"}, 64'(err), 64'(m_err));
    check({tag, ".sat_sum"}, 64'(s_sum), 64'(m_sum[0]));
    check({tag, ".sat_carry"}, 64'(s_carry), 64'(m_carry[0]));
    check({tag, ".sat_op_count"}, 64'(s_op_count), 64'(sat_n));
    check({tag, ".sat_err"}, 64'(s_err), 64'(1'b0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    m_sum = '0; m_carry = '0; m_ov = 1'b0; m_cnt = 0; m_err = 1'b0;

    //           rst   iv    a      b      sum    carry  ov    cnt sat
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1, 1};
    tbl[3]  = '{1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 4'h0, 1'b1, 2, 2};
    tbl[4]  = '{1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 3, 3};
    tbl[5]  = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 4, 3};
    tbl[6]  = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 5, 3};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 5, 3};
    tbl[8]  = '{1'b0, 1'b1, 4'hC, 4'hA, 4'h6, 4'h8, 1'b1, 6, 3};
    tbl[9]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 4'h3, 4'h5, 4'h6, 4'h1, 1'b1, 1, 1};

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].rst, tbl[i].iv, tbl[i].a, tbl[i].b);
      check($sformatf("tbl%0d.sum", i), 64'(sum), 64'(tbl[i].e_sum));
      check($sformatf("tbl%0d.carry", i), 64'(carry), 64'(tbl[i].e_carry));
      check($sformatf("tbl%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      check($sformatf("tbl%0d.op_count", i), 64'(op_count), 64'(tbl[i].e_cnt));
      check($sformatf("tbl%0d.err", i), 64'(err), 64'(1'b0));
      check($sformatf("tbl%0d.sat_sum", i), 64'(s_sum), 64'(tbl[i].e_sum[0]));
      check($sformatf("tbl%0d.sat_carry", i), 64'(s_carry), 64'(tbl[i].e_carry[0]));
      check($sformatf("tbl%0d.sat_op_count", i), 64'(s_op_count), 64'(tbl[i].e_sat));
      check($sformatf("tbl%0d.sat_out_valid", i), 64'(s_out_valid), 64'(tbl[i].e_ov));
    end

    // Saturation of the narrow counter, then reset mid-stream with in_valid held high.
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 4'(i), 4'(i + 3));
    check_model("sat5");
    check("sat5.sat_op_count_literal", 64'(s_op_count), 64'd3);
    apply(1'b1, 1'b1, 4'hF, 4'hF);
    check_model("midrst");
    check("midrst.sat_out_valid", 64'(s_out_valid), 64'd0);

    // Randomized run against the model.
    for (int i = 0; i < 1000; i++) begin
      logic r, iv;
      r  = ($urandom_range(0, 63) == 0);
      iv = ($urandom_range(0, 3) != 0);
      apply(r, iv, 4'($urandom), 4'($urandom));
      check_model("rand");
    end

`ifdef HALF_ADDER_SELFCHECK_EN
    // Break lane 0 and confirm the sticky error flag.
    force u_dut.g_lane[0].n1 = 1'b0;
    apply(1'b0, 1'b1, 4'h0, 4'h0);
    check("force.err", 64'(err), 64'd1);
    release u_dut.g_lane[0].n1;
    apply(1'b0, 1'b1, 4'h5, 4'h3);
    check("sticky.err", 64'(err), 64'd1);
    apply(1'b0, 1'b0, 4'h0, 4'h0);
    check("sticky_idle.err", 64'(err), 64'd1);
    apply(1'b1, 1'b0, 4'h0, 4'h0);
    check("rst.err", 64'(err), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
